// File: rtl/relu_grad_mask_pkg.sv
// Shared definitions for the forward nonlinear unit and the ReLU gradient mask.
// The predicate takes sign and nonzero flags so it stays independent of element width.
package relu_grad_mask_pkg;

  localparam logic [2:0] FUN_RELU = 3'b001;

  // Strictly positive: sign clear and value nonzero.
  function automatic logic relu_mask(input logic sign_bit, input logic nonzero);
    return !sign_bit && nonzero;
  endfunction

endpackage

// File: rtl/relu_grad_mask_bit_fifo.sv
// One-bit-wide mask FIFO with push/pop/clear and registered occupancy flags.
module relu_grad_mask_bit_fifo #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // No bypass: a full FIFO refuses a push even when a pop happens alongside it.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/relu_grad_mask.sv
// Records ReLU forward mask bits and replays them in order to gate the gradient stream.
module relu_grad_mask
  import relu_grad_mask_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     fwd_valid,
  input  logic [WIDTH-1:0]         fwd_in,
  output logic                     fwd_ready,
  input  logic                     grad_valid,
  input  logic [WIDTH-1:0]         grad_in,
  output logic                     grad_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  logic             mask_in, mask_out;
  logic             grad_acc;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  assign mask_in    = relu_mask(fwd_in[WIDTH-1], |fwd_in);
  assign fwd_ready  = !full;
  assign grad_ready = !empty && (!out_valid_q || out_ready);
  assign grad_acc   = grad_valid && grad_ready && !clear;

  relu_grad_mask_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fwd_valid),
    .din   (mask_in),
    .pop   (grad_acc),
    .dout  (mask_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (grad_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = mask_out ? grad_in : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_relu_grad_mask.sv
// Scoreboard bench for relu_grad_mask: expected outputs queued at accept, popped by a monitor.
module tb_relu_grad_mask;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [31:0] fwd_in = '0;
  logic        fwd_ready;
  logic        grad_valid = 1'b0;
  logic [31:0] grad_in = '0;
  logic        grad_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;
  logic [8:0]  count;
  logic        full;
  logic        empty;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_word;
  logic        acc;

  relu_grad_mask #(.WIDTH(32), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fwd_valid  (fwd_valid),
    .fwd_in     (fwd_in),
    .fwd_ready  (fwd_ready),
    .grad_valid (grad_valid),
    .grad_in    (grad_in),
    .grad_ready (grad_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected no output at %0t", out_data, $time);
      end else begin
        exp_word = sb.pop_front();
        chk("out_data", out_data, exp_word);
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1 with valids dropped.
  task automatic step(input logic pv, input logic [31:0] fv, input logic gv,
                      input logic [31:0] gval, input logic [31:0] gexp, output logic a);
    fwd_valid  = pv;
    fwd_in     = fv;
    grad_valid = gv;
    grad_in    = gval;
    @(negedge clk);
    a = gv && grad_ready;
    if (a) sb.push_back(gexp);
    @(posedge clk);
    #1;
    fwd_valid  = 1'b0;
    grad_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, a);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sb.delete();
  endtask

  function automatic logic [31:0] fval(input int k);
    return (k % 2 == 0) ? 32'(k + 1) : -32'(k + 1);
  endfunction

  function automatic logic [31:0] gexp(input int k);
    return (k % 2 == 0) ? 32'(1000 + k) : 32'd0;
  endfunction

  initial begin
    #12;
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("rst_grad_ready", 32'(grad_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic masking: 5 -> pass, 0 -> zero, -3 -> zero, max positive -> pass
    step(1'b1, 32'd5, 1'b0, '0, '0, acc);
    chk("empty_after_push", 32'(empty), 32'd0);
    step(1'b1, 32'd0, 1'b0, '0, '0, acc);
    step(1'b1, 32'hFFFF_FFFD, 1'b0, '0, '0, acc);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, '0, '0, acc);
    chk("count_4", 32'(count), 32'd4);
    step(1'b0, '0, 1'b1, 32'd10, 32'd10, acc);
    chk("acc_10", 32'(acc), 32'd1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    step(1'b0, '0, 1'b1, 32'd20, 32'd0, acc);
    chk("acc_20", 32'(acc), 32'd1);
    step(1'b0, '0, 1'b1, 32'd30, 32'd0, acc);
    chk("acc_30", 32'(acc), 32'd1);
    step(1'b0, '0, 1'b1, 32'd40, 32'd40, acc);
    chk("acc_40", 32'(acc), 32'd1);
    idle(2);
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill to capacity; 257th push refused
    do_clear();
    for (int i = 0; i < 256; i++) step(1'b1, 32'(i + 1), 1'b0, '0, '0, acc);
    chk("full_count", 32'(count), 32'd256);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_fwd_ready", 32'(fwd_ready), 32'd0);
    step(1'b1, 32'd999, 1'b0, '0, '0, acc);
    chk("overflow_count", 32'(count), 32'd256);

    // Pointer wrap with simultaneous push/pop at count 3
    do_clear();
    for (int k = 0; k < 253; k++) step(1'b1, fval(k), 1'b0, '0, '0, acc);
    for (int k = 0; k < 250; k++) step(1'b0, '0, 1'b1, 32'(1000 + k), gexp(k), acc);
    chk("wrap_pre_count", 32'(count), 32'd3);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, fval(253 + j), 1'b1, 32'(1250 + j), gexp(250 + j), acc);
      chk("wrap_acc", 32'(acc), 32'd1);
      chk("wrap_count", 32'(count), 32'd3);
    end
    for (int k = 260; k < 263; k++) step(1'b0, '0, 1'b1, 32'(1000 + k), gexp(k), acc);
    idle(2);
    chk("wrap_drained", 32'(empty), 32'd1);

    // Backpressure: output held, gradient stalled
    do_clear();
    step(1'b1, 32'd1, 1'b0, '0, '0, acc);
    step(1'b1, 32'd2, 1'b0, '0, '0, acc);
    out_ready = 1'b0;
    step(1'b0, '0, 1'b1, 32'd11, 32'd11, acc);
    chk("bp_acc", 32'(acc), 32'd1);
    grad_valid = 1'b1;
    grad_in    = 32'd22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_grad_ready", 32'(grad_ready), 32'd0);
      chk("bp_out_data", out_data, 32'd11);
      chk("bp_count", 32'(count), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    step(1'b0, '0, 1'b1, 32'd22, 32'd22, acc);
    chk("bp_release_acc", 32'(acc), 32'd1);
    idle(2);

    // Gradient arriving on an empty FIFO
    do_clear();
    grad_valid = 1'b1;
    grad_in    = 32'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mt_grad_ready", 32'(grad_ready), 32'd0);
      chk("mt_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    step(1'b1, 32'd7, 1'b1, 32'd9, 32'd9, acc);
    chk("mt_same_cycle_acc", 32'(acc), 32'd0);
    step(1'b0, '0, 1'b1, 32'd9, 32'd9, acc);
    chk("mt_next_acc", 32'(acc), 32'd1);
    chk("mt_out_valid_after", 32'(out_valid), 32'd1);
    chk("mt_out_data", out_data, 32'd9);
    idle(2);

    // Clear with pending output and a push in the clear cycle
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i + 1), 1'b0, '0, '0, acc);
    step(1'b0, '0, 1'b1, 32'd50, 32'd50, acc);
    chk("cl_count_pre", 32'(count), 32'd4);
    chk("cl_valid_pre", 32'(out_valid), 32'd1);
    clear     = 1'b1;
    fwd_valid = 1'b1;
    fwd_in    = 32'd3;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    fwd_valid = 1'b0;
    sb.delete();
    chk("cl_count", 32'(count), 32'd0);
    chk("cl_empty", 32'(empty), 32'd1);
    chk("cl_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i + 1), 1'b0, '0, '0, acc);
    step(1'b0, '0, 1'b1, 32'd60, 32'd60, acc);
    chk("ar_count_pre", 32'(count), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("ar_grad_ready", 32'(grad_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
